// File: rtl/freq_sel_ctrl.sv
// -----------------------------------------------------------------------------
// freq_sel_ctrl
// Front-panel frequency selector for the divider. Debounces the up/down
// buttons, steps a saturating 3-bit index (with press-and-hold auto-repeat),
// accepts a direct load, and drives the divider's frequency code.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   btn_up    in   raw up button (asynchronous, bouncing)
//   btn_down  in   raw down button (asynchronous, bouncing)
//   load_en   in   one-cycle request to load load_idx (wins over a step)
//   load_idx  in   index to load, 0..7
//   frecnum   out  frequency code for the divider (registered)
//   freq_idx  out  current index (registered)
//   changed   out  one-cycle pulse after freq_idx takes a new value
// -----------------------------------------------------------------------------
module freq_sel_ctrl #(
  parameter int unsigned DEB_CYCLES    = 12500,
  parameter int unsigned HOLD_CYCLES   = 2500000,
  parameter int unsigned REPEAT_CYCLES = 625000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       load_en,
  input  logic [2:0] load_idx,
  output logic [7:0] frecnum,
  output logic [2:0] freq_idx,
  output logic       changed
);

  localparam int unsigned DEB_W   = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HOLD     = 2'd1,
    S_REPEAT   = 2'd2,
    S_WAIT_REL = 2'd3
  } state_t;

  // Bit 0 = up button, bit 1 = down button throughout.
  logic [1:0]       w_raw;
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_deb;
  logic [DEB_W-1:0] r_deb_cnt [2];

  logic [1:0]       r_vld;
  logic             r_armed;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_dir;
  logic [TMR_W-1:0] r_tmr;

  logic             w_u;
  logic             w_d;
  logic             w_held;
  logic             w_other;
  logic             w_step_up;
  logic             w_step_dn;
  logic             w_tmr_clr;
  logic             w_dir_load;

  logic [2:0]       r_freq_idx;
  logic [2:0]       w_idx_nxt;
  logic [7:0]       r_frecnum;
  logic [7:0]       w_code_nxt;
  logic             r_changed;

  assign w_raw = {btn_down, btn_up};

  // Two-flop synchronizer plus per-button debounce counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
      r_deb   <= 2'b00;
      for (int i = 0; i < 2; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_LAST) begin
          r_deb[i]     <= ~r_deb[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // A button still held through reset must not cause a step once reset is
  // released: the FSM only sees the buttons after both have been observed
  // released (synchronizer filled, synchronized and debounced levels all low).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld   <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_vld   <= {r_vld[0], 1'b1};
      r_armed <= r_armed | (r_vld[1] & ~(|r_sync2) & ~(|r_deb));
    end
  end

  assign w_u     = r_deb[0] & r_armed;
  assign w_d     = r_deb[1] & r_armed;
  assign w_held  = r_dir ? w_u : w_d;
  assign w_other = r_dir ? w_d : w_u;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_u && w_d)      w_state_nxt = S_WAIT_REL;
        else if (w_u ^ w_d)  w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (!w_held)                w_state_nxt = S_IDLE;
        else if (w_other)           w_state_nxt = S_WAIT_REL;
        else if (r_tmr == HOLD_LAST) w_state_nxt = S_REPEAT;
      end
      S_REPEAT: begin
        if (!w_held)       w_state_nxt = S_IDLE;
        else if (w_other)  w_state_nxt = S_WAIT_REL;
      end
      S_WAIT_REL: begin
        if (!w_u && !w_d)  w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: step requests, timer clear, direction capture.
  always_comb begin
    w_step_up  = 1'b0;
    w_step_dn  = 1'b0;
    w_tmr_clr  = 1'b0;
    w_dir_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_u ^ w_d) begin
          w_step_up  = w_u;
          w_step_dn  = w_d;
          w_tmr_clr  = 1'b1;
          w_dir_load = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_held && !w_other && (r_tmr == HOLD_LAST)) begin
          w_step_up = r_dir;
          w_step_dn = ~r_dir;
          w_tmr_clr = 1'b1;
        end
      end
      S_REPEAT: begin
        if (w_held && !w_other && (r_tmr == REP_LAST)) begin
          w_step_up = r_dir;
          w_step_dn = ~r_dir;
          w_tmr_clr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Hold/repeat timer and held-button direction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmr <= '0;
      r_dir <= 1'b0;
    end else begin
      if (w_tmr_clr)                                   r_tmr <= '0;
      else if (r_state == S_HOLD || r_state == S_REPEAT) r_tmr <= r_tmr + TMR_W'(1);
      else                                             r_tmr <= '0;
      if (w_dir_load) r_dir <= w_u;
    end
  end

  // Next index: load wins, steps saturate at 0 and 7.
  always_comb begin
    w_idx_nxt = r_freq_idx;
    if (load_en)                              w_idx_nxt = load_idx;
    else if (w_step_up && r_freq_idx != 3'd7) w_idx_nxt = r_freq_idx + 3'd1;
    else if (w_step_dn && r_freq_idx != 3'd0) w_idx_nxt = r_freq_idx - 3'd1;
  end

  // Index-to-code map.
  always_comb begin
    w_code_nxt = 8'd30;
    case (w_idx_nxt)
      3'd0: w_code_nxt = 8'd30;
      3'd1: w_code_nxt = 8'd50;
      3'd2: w_code_nxt = 8'd75;
      3'd3: w_code_nxt = 8'd100;
      3'd4: w_code_nxt = 8'd125;
      3'd5: w_code_nxt = 8'd150;
      3'd6: w_code_nxt = 8'd175;
      3'd7: w_code_nxt = 8'd200;
      default: w_code_nxt = 8'd30;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_freq_idx <= 3'd0;
      r_frecnum  <= 8'd30;
      r_changed  <= 1'b0;
    end else begin
      r_freq_idx <= w_idx_nxt;
      r_frecnum  <= w_code_nxt;
      r_changed  <= (w_idx_nxt != r_freq_idx);
    end
  end

  assign freq_idx = r_freq_idx;
  assign frecnum  = r_frecnum;
  assign changed  = r_changed;

endmodule

// File: tb/tb_freq_sel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freq_sel_ctrl
// Scoreboard bench for freq_sel_ctrl: each stimulus pushes the index change it
// should cause (with its cycle number); a negedge monitor pops and compares
// every index change the DUT makes, and checks the code map and the changed
// pulse on every cycle.
// -----------------------------------------------------------------------------
module tb_freq_sel_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 20;
  localparam int unsigned REP  = 8;
  localparam int unsigned LAT  = DEB + 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up;
  logic       btn_down;
  logic       load_en;
  logic [2:0] load_idx;
  logic [7:0] frecnum;
  logic [2:0] freq_idx;
  logic       changed;

  freq_sel_ctrl #(
    .DEB_CYCLES    (DEB),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .load_en  (load_en),
    .load_idx (load_idx),
    .frecnum  (frecnum),
    .freq_idx (freq_idx),
    .changed  (changed)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  idx;
  } ev_t;

  ev_t        sb_q[$];
  int         total = 0;
  int         bad   = 0;
  logic [2:0] exp_idx;
  logic [2:0] prev_idx = 3'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] code_of(input logic [2:0] idx);
    logic [7:0] tbl [8] = '{8'd30, 8'd50, 8'd75, 8'd100, 8'd125, 8'd150, 8'd175, 8'd200};
    return tbl[idx];
  endfunction

  // Record an expected index change at an absolute cycle number.
  task automatic push_ev(input int unsigned at, input logic [2:0] idx);
    ev_t e;
    e.cyc = at;
    e.idx = idx;
    sb_q.push_back(e);
    exp_idx = idx;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [2:0] v);
    load_en  = 1'b1;
    load_idx = v;
    if (v != exp_idx) push_ev(cyc + 1, v);
    tick(1);
    load_en = 1'b0;
    tick(2);
  endtask

  // Monitor: every index change must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      prev_idx = 3'd0;
    end else begin
      if (freq_idx != prev_idx) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_step", 32'(freq_idx), 32'(prev_idx));
        end else begin
          ev_t e;
          e = sb_q.pop_front();
          chk("step_cycle", cyc, e.cyc);
          chk("step_idx", 32'(freq_idx), 32'(e.idx));
        end
      end
      chk("code_map", 32'(frecnum), 32'(code_of(freq_idx)));
      chk("changed", 32'(changed), 32'(freq_idx != prev_idx));
      prev_idx = freq_idx;
    end
  end

  initial begin
    int unsigned c;
    reset    = 1'b1;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    load_en  = 1'b0;
    load_idx = 3'd0;
    exp_idx  = 3'd0;
    #1;
    chk("rst_code", 32'(frecnum), 32'd30);
    chk("rst_idx", 32'(freq_idx), 32'd0);
    chk("rst_changed", 32'(changed), 32'd0);
    tick(3);
    reset = 1'b0;
    tick(100);
    chk("idle_code", 32'(frecnum), 32'd30);

    // Clean up press, 10 cycles.
    btn_up = 1'b1;
    push_ev(cyc + LAT, 3'd1);
    tick(10);
    btn_up = 1'b0;
    tick(30);

    // Bouncing down press from index 3.
    do_load(3'd3);
    for (int i = 0; i < 6; i++) begin
      btn_down = (i % 2 == 0);
      tick(2);
    end
    btn_down = 1'b1;
    push_ev(cyc + LAT, 3'd2);
    tick(10);
    btn_down = 1'b0;
    tick(30);

    // Press-and-hold auto-repeat from index 0.
    do_load(3'd0);
    btn_up = 1'b1;
    c = cyc + LAT;
    push_ev(c, 3'd1);
    push_ev(c + HOLD, 3'd2);
    for (int k = 1; k <= 4; k++) push_ev(c + HOLD + REP * k, 3'(2 + k));
    tick(60);
    btn_up = 1'b0;
    tick(30);

    // Holding up at index 7 saturates silently.
    do_load(3'd7);
    btn_up = 1'b1;
    tick(40);
    btn_up = 1'b0;
    tick(30);
    chk("sat_code", 32'(frecnum), 32'd200);

    // Both buttons, then down released first: no step until both released.
    do_load(3'd3);
    btn_up   = 1'b1;
    btn_down = 1'b1;
    tick(10);
    btn_down = 1'b0;
    tick(15);
    btn_up = 1'b0;
    tick(20);
    btn_up = 1'b1;
    push_ev(cyc + LAT, 3'd4);
    tick(10);
    btn_up = 1'b0;
    tick(30);

    // Load colliding with a debounced up-step from index 2, then repeat.
    do_load(3'd2);
    btn_up = 1'b1;
    c = cyc;
    tick(LAT - 1);
    load_en  = 1'b1;
    load_idx = 3'd5;
    push_ev(c + LAT, 3'd5);
    tick(1);
    load_en = 1'b0;
    push_ev(c + LAT + HOLD, 3'd6);
    push_ev(c + LAT + HOLD + REP, 3'd7);
    tick(31);

    // Reset mid-repeat with the button still held.
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_code", 32'(frecnum), 32'd30);
    chk("midrst_idx", 32'(freq_idx), 32'd0);
    chk("midrst_changed", 32'(changed), 32'd0);
    chk("midrst_sb_empty", 32'(sb_q.size()), 32'd0);
    exp_idx = 3'd0;
    tick(3);
    reset = 1'b0;
    tick(30);
    chk("held_after_rst_idx", 32'(freq_idx), 32'd0);
    btn_up = 1'b0;
    tick(20);
    btn_up = 1'b1;
    push_ev(cyc + LAT, 3'd1);
    tick(10);
    btn_up = 1'b0;
    tick(30);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/freq_sel_ctrl.md
# freq_sel_ctrl

Front-panel controller for the frequency divider. Debounces up/down push-buttons, steps a 3-bit index through the eight supported frequency codes, and drives the divider's `frecnum` input. It also accepts a direct load from other control logic and supports press-and-hold auto-repeat. It sits between the board buttons and `Divisor_f`, in the same clock domain.

## Interface
- `DEB_CYCLES`, default 12500: consecutive stable cycles before the debounced button level changes.
- `HOLD_CYCLES`, default 2500000: cycles a single button must be held before auto-repeat starts.
- `REPEAT_CYCLES`, default 625000: cycles between auto-repeat steps.
- `clk`  in  1: system clock; all logic is rising-edge.
- `reset`  in  1: asynchronous, active-high reset.
- `btn_up`  in  1: raw, asynchronous, bouncing button; selects the next higher frequency.
- `btn_down`  in  1: raw, asynchronous, bouncing button; selects the next lower frequency.
- `load_en`  in  1: synchronous, one-cycle request to load `load_idx`.
- `load_idx`  in  3: index to load, 0..7.
- `frecnum`  out  8: frequency code sent to the divider.
- `freq_idx`  out  3: current index.
- `changed`  out  1: one-cycle pulse on the cycle after `freq_idx` changes value.

## Operation
- Index-to-code map (registered output): 0→30, 1→50, 2→75, 3→100, 4→125, 5→150, 6→175, 7→200.
- Reset values:
  - `freq_idx` = 0, `frecnum` = 30, `changed` = 0.
  - FSM = IDLE; all counters = 0.
  - Synchronizer and debounced levels = 0.
- Input path, per button:
  - 2-flop synchronizer.
  - Debounce counter. It clears whenever the synchronized value equals the debounced level. Otherwise it increments, and on reaching `DEB_CYCLES`-1 the debounced level toggles and the counter clears.
- FSM, driven by debounced levels `u` and `d`:
  - IDLE:
    - `u` xor `d` → perform step (+1 for `u`, −1 for `d`), clear hold counter, go to HOLD.
    - `u` and `d` both high → go to WAIT_REL, no step.
  - HOLD:
    - Button released → IDLE.
    - Other button also high → WAIT_REL.
    - Hold counter reaches `HOLD_CYCLES`-1 → step, clear counter, go to REPEAT.
  - REPEAT:
    - Release → IDLE.
    - Both high → WAIT_REL.
    - Counter reaches `REPEAT_CYCLES`-1 → step, clear counter.
  - WAIT_REL: go to IDLE only when `u` = `d` = 0.
- Step arithmetic saturates: +1 at index 7 and −1 at index 0 leave the index unchanged. There is no wrap.
- `load_en` has priority over any step in the same cycle:
  - `freq_idx` ← `load_idx` on that edge; the competing step is discarded.
  - FSM state and counters advance normally.
- `changed` asserts only when the new index differs from the old one. Saturated steps and same-value loads produce no pulse.
- `reset` mid-hold or mid-debounce aborts everything immediately. No step is taken after reset deasserts until a fresh debounced press occurs.

## Timing
- Clean press latency: `freq_idx`/`frecnum` update exactly `DEB_CYCLES`+3 rising edges after the first edge that samples the raw button high.
  - 2 edges for the synchronizer.
  - `DEB_CYCLES` edges for the debouncer.
  - 1 edge for the FSM step.
- Load latency: `freq_idx` and `frecnum` update on the same edge that samples `load_en`=1.
- `changed` is high for exactly the 1 cycle after the update.
- Auto-repeat: first extra step `HOLD_CYCLES` cycles after the initial step; then one step every `REPEAT_CYCLES` cycles.
- A raw glitch shorter than `DEB_CYCLES` cycles (after synchronization) produces no step.

## Test plan
Bench parameters: `DEB_CYCLES`=4, `HOLD_CYCLES`=20, `REPEAT_CYCLES`=8.
- Reset then idle: `frecnum`=30, `freq_idx`=0, `changed`=0, held for 100 cycles.
- Clean `btn_up` press for 10 cycles → `frecnum` goes 30→50 exactly 7 edges after the press is sampled; a single `changed` pulse; no further step after release.
- Bounce on `btn_down` (toggling every 2 cycles for 12 cycles, then stable high at index 3) → exactly one step 100→75; no step during the bounce.
- Hold `btn_up` for 60 cycles from index 0 → steps at t0, t0+20, t0+28, t0+36, t0+44, t0+52 give `frecnum` 50,75,100,125,150,175.
  - Continue holding from index 7 → stays 200 with no `changed` pulse.
- Both buttons pressed together, then `btn_down` released with `btn_up` still held → no step until both are released. A new `btn_up` press then steps normally.
- `load_en` with `load_idx`=5 on the same edge as a debounced up-step from index 2 → `frecnum`=150, one `changed` pulse.
  - `reset` asserted mid-REPEAT → outputs return to 30/0 asynchronously; no step after reset deasserts while the button is still held, until release and a new press.
